memory_copy_master: RTL and testbench
=====================================

MEMORY_COPY_MASTER -- requirements
Module: memory_copy_master

Interface
REQ-001 SHALL have parameter LEN_W, default 8, meaning width of the word-count input.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port Start  input  1  one-cycle request to begin a transfer.
REQ-005 SHALL have port Src_addr  input  32  source byte address.
REQ-006 SHALL have port Dst_addr  input  32  destination byte address.
REQ-007 SHALL have port Length  input  LEN_W  number of 32-bit words to move.
REQ-008 SHALL have port Busy  output  1  high while a transfer is in progress.
REQ-009 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port Address  output  32  memory byte address.
REQ-011 SHALL have port Write_data  output  32  memory write word.
REQ-012 SHALL have port MemRead  output  1  memory read enable.
REQ-013 SHALL have port MemWrite  output  1  memory write enable; memory samples it on the clk rising edge.
REQ-014 SHALL have port Mem_data  input  32  memory read word; valid combinationally in the same cycle as MemRead.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-016 In IDLE, on Start=1, SHALL latch the following inputs:
- Src_addr and Dst_addr, each with bits [1:0] forced to 0.
- Length.
REQ-017 On the cycle after Start, SHALL enter READ if Length>0, otherwise DONE with no memory access.
REQ-018 In READ, SHALL drive Address=src and MemRead=1, capture Mem_data into a word buffer at the clock edge, then go to WRITE.
REQ-019 In WRITE, SHALL drive Address=dst, Write_data=buffer and MemWrite=1.
REQ-020 At the end of each WRITE cycle, SHALL:
- add 4 to src and to dst, modulo 2^32 (wrap-around, no error);
- decrement the count;
- go to DONE if the count reaches 0, otherwise go to READ.
REQ-021 In DONE, SHALL assert Done=1 for exactly one cycle, then return to IDLE.
REQ-022 Latency from the Start edge to the Done cycle SHALL be 2*Length+1 cycles.
REQ-023 Busy SHALL be 1 in READ, WRITE and DONE, and 0 in IDLE.
REQ-024 Start while not in IDLE SHALL be ignored, with no effect on the transfer in progress.
REQ-025 MemRead and MemWrite SHALL never be high in the same cycle.
REQ-026 In IDLE and DONE, Address, Write_data, MemRead and MemWrite SHALL all be 0.
REQ-027 Words SHALL be copied in ascending address order regardless of any overlap between source and destination regions.

Reset
REQ-028 While reset=0, SHALL force state IDLE, with all outputs and internal registers at 0.
REQ-029 Reset asserted mid-transfer SHALL deassert MemWrite immediately (asynchronously) and abandon the transfer without producing a Done pulse.

Configuration
REQ-030 With MEM_COPY_FILL_EN defined, SHALL add two inputs:
- Fill  1  fill-mode request, latched at Start;
- Fill_data  32  fill word, latched at Start.
REQ-031 With MEM_COPY_FILL_EN defined and Fill=1 latched, SHALL skip READ, write Fill_data to Length consecutive destination words, and give a latency of Length+1 cycles.
REQ-032 Without MEM_COPY_FILL_EN, the Fill and Fill_data ports and the fill logic SHALL be absent, and behaviour SHALL be copy-only as above.

Structure
REQ-033 Package mem_copy_pkg SHALL hold:
- the FSM state typedef (IDLE, READ, WRITE, DONE);
- constant WORD_BYTES=4.
REQ-034 The block SHALL be a single module containing FSM and datapath, with no sub-module.

Verification (bench drives a 256-word single-port memory model)
REQ-035 Copy: memory[0x80..0x8C]=1,2,3,4; Start, Src=0x80, Dst=0x100, Length=4 -> memory[0x100..0x10C]=1,2,3,4, Done on cycle 9, Busy high for cycles 1-9.
REQ-036 Zero length: Start with Length=0 -> Done on cycle 1, MemRead and MemWrite never asserted.
REQ-037 Misalignment and busy Start: Src=0x83, Dst=0x202, Length=1 -> accesses at 0x80 and 0x200; a second Start during Busy with Dst=0x300 -> memory[0x300] unchanged.
REQ-038 Reset mid-transfer: reset=0 during the second WRITE of a Length=4 copy -> only the first word written, no Done, Busy=0, and a new Start succeeds.
REQ-039 Wrap-around: Dst=0xFFFFFFFC, Length=2 -> writes at 0xFFFFFFFC then 0x00000000.
REQ-040 Fill (only with MEM_COPY_FILL_EN): Fill=1, Fill_data=0xDEADBEEF, Dst=0x40, Length=3 -> three words equal 0xDEADBEEF, Done on cycle 4, MemRead never asserted.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory copy master.
// Holds the FSM state encoding and the word size used to step addresses.
package mem_copy_pkg;

  localparam int unsigned WORD_BYTES = 4;

  // Byte-offset bits of a word address. They are cleared when addresses are latched.
  localparam logic [31:0] WORD_OFFSET_MASK = 32'(WORD_BYTES - 1);

  typedef logic [1:0] mc_state_t;

  localparam mc_state_t IDLE  = 2'd0;
  localparam mc_state_t READ  = 2'd1;
  localparam mc_state_t WRITE = 2'd2;
  localparam mc_state_t DONE  = 2'd3;

endpackage

// File: rtl/memory_copy_master.sv
// Memory copy master: moves Length 32-bit words from Src_addr to Dst_addr
// through a single-port memory. Each word takes one READ cycle followed by
// one WRITE cycle, in ascending address order. A one-cycle Done pulse
// marks completion.
//
// Optional feature: MEM_COPY_FILL_EN adds Fill/Fill_data. With Fill latched
// high, READ is skipped and Fill_data is written to Length destination words.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   Start      - one-cycle transfer request, honoured only in IDLE
//   Src_addr   - source byte address (bits [1:0] ignored)
//   Dst_addr   - destination byte address (bits [1:0] ignored)
//   Length     - number of words to move
//   Fill       - fill-mode request (MEM_COPY_FILL_EN only)
//   Fill_data  - fill word (MEM_COPY_FILL_EN only)
//   Busy       - high in READ, WRITE and DONE
//   Done       - one-cycle completion pulse
//   Address    - memory byte address
//   Write_data - memory write word
//   MemRead    - memory read enable
//   MemWrite   - memory write enable
//   Mem_data   - memory read word, valid combinationally with MemRead
module memory_copy_master
  import mem_copy_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [31:0]      Src_addr,
  input  logic [31:0]      Dst_addr,
  input  logic [LEN_W-1:0] Length,
`ifdef MEM_COPY_FILL_EN
  input  logic             Fill,
  input  logic [31:0]      Fill_data,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [31:0]      Address,
  output logic [31:0]      Write_data,
  output logic             MemRead,
  output logic             MemWrite,
  input  logic [31:0]      Mem_data
);

  mc_state_t        state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [31:0]      buf_q, buf_d;
`ifdef MEM_COPY_FILL_EN
  logic             fill_q, fill_d;
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    count_d = count_q;
    buf_d   = buf_q;
`ifdef MEM_COPY_FILL_EN
    fill_d  = fill_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          src_d   = Src_addr & ~WORD_OFFSET_MASK;
          dst_d   = Dst_addr & ~WORD_OFFSET_MASK;
          count_d = Length;
`ifdef MEM_COPY_FILL_EN
          fill_d  = Fill;
          // In fill mode the word buffer holds the fill word for every write.
          if (Fill) begin
            buf_d = Fill_data;
          end
          if (Length == '0) begin
            state_d = DONE;
          end else if (Fill) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
`else
          state_d = (Length == '0) ? DONE : READ;
`endif
        end
      end

      READ: begin
        buf_d   = Mem_data;
        state_d = WRITE;
      end

      WRITE: begin
        // Address arithmetic wraps modulo 2^32 by construction.
        src_d   = src_q + 32'(WORD_BYTES);
        dst_d   = dst_q + 32'(WORD_BYTES);
        count_d = count_q - LEN_W'(1);
        if (count_q == LEN_W'(1)) begin
          state_d = DONE;
        end else begin
`ifdef MEM_COPY_FILL_EN
          state_d = fill_q ? WRITE : READ;
`else
          state_d = READ;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory-side outputs are decoded from the registered state only, so the
  // asynchronous reset clears MemWrite as soon as reset falls.
  always_comb begin
    Address    = '0;
    Write_data = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    unique case (state_q)
      READ: begin
        Address = src_q;
        MemRead = 1'b1;
      end
      WRITE: begin
        Address    = dst_q;
        Write_data = buf_q;
        MemWrite   = 1'b1;
      end
      default: begin
        Address    = '0;
        Write_data = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
      end
    endcase
  end

  assign Busy = (state_q != IDLE);
  assign Done = (state_q == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      buf_q   <= '0;
`ifdef MEM_COPY_FILL_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      buf_q   <= buf_d;
`ifdef MEM_COPY_FILL_EN
      fill_q  <= fill_d;
`endif
    end
  end

endmodule

// File: tb/tb_memory_copy_master.sv
// Scoreboard bench for memory_copy_master. Stimulus pushes expected memory
// reads, writes and the Done pulse (with their cycle offsets from Start)
// into a queue; a negedge monitor pops and compares whenever the DUT drives
// MemRead, MemWrite or Done. Build with MEM_COPY_FILL_EN to cover fill mode.
module tb_memory_copy_master;

  localparam int unsigned LenW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            Start = 1'b0;
  logic [31:0]     Src_addr = '0;
  logic [31:0]     Dst_addr = '0;
  logic [LenW-1:0] Length = '0;
`ifdef MEM_COPY_FILL_EN
  logic            Fill = 1'b0;
  logic [31:0]     Fill_data = '0;
`endif
  logic            Busy;
  logic            Done;
  logic [31:0]     Address;
  logic [31:0]     Write_data;
  logic            MemRead;
  logic            MemWrite;
  logic [31:0]     Mem_data;

  memory_copy_master #(.LEN_W(LenW)) dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .Src_addr   (Src_addr),
    .Dst_addr   (Dst_addr),
    .Length     (Length),
`ifdef MEM_COPY_FILL_EN
    .Fill       (Fill),
    .Fill_data  (Fill_data),
`endif
    .Busy       (Busy),
    .Done       (Done),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Mem_data   (Mem_data)
  );

  always #5 clk = ~clk;

  // 256-word single-port memory, byte address bits [9:2] select the word.
  logic [31:0] mem [256];
  assign Mem_data = mem[Address[9:2]];
  always @(posedge clk) begin
    if (MemWrite) mem[Address[9:2]] <= Write_data;
  end

  typedef struct {
    int          kind;  // 0 read, 1 write, 2 done
    logic [31:0] addr;
    logic [31:0] data;
    int          rel;   // cycle offset from the Start edge
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sentinel(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data,
                      input int rel);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.rel  = rel;
    exp_q.push_back(e);
  endtask

  // Monitor: one scoreboard pop per presented event.
  always @(negedge clk) begin
    int  rel;
    int  kind;
    ev_t e;
    if (reset) begin
      rel = cyc - start_cyc + 1;
      if (MemRead && MemWrite) check("rd_wr_exclusive", 32'd1, 32'd0);
      if (MemRead || MemWrite || Done) begin
        kind = MemRead ? 0 : (MemWrite ? 1 : 2);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: kind %0d addr 0x%08h at cycle %0d, expected none",
                   kind, Address, rel);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", 32'(kind), 32'(e.kind));
          check("event_addr", Address, e.addr);
          if (kind == 1) check("write_data", Write_data, e.data);
          if (kind == 2) check("done_write_data_zero", Write_data, 32'h0);
          check("event_cycle", 32'(rel), 32'(e.rel));
        end
      end
    end
  end

  task automatic drive_start(input logic [31:0] src, input logic [31:0] dst, input int len,
                             input bit fill, input logic [31:0] fdata);
    @(negedge clk);
    Src_addr = src;
    Dst_addr = dst;
    Length   = LenW'(len);
`ifdef MEM_COPY_FILL_EN
    Fill      = fill;
    Fill_data = fdata;
`else
    if (fill || (fdata != 0)) $display("note: fill request ignored in copy-only build");
`endif
    Start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    Start = 1'b0;
  endtask

  // Full transfer with model-built expectations; optional Start poke while busy.
  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input bit fill, input logic [31:0] fdata, input bit poke);
    int          tot;
    logic [31:0] sa;
    logic [31:0] da;
    sa = src & ~32'h3;
    da = dst & ~32'h3;
    if (fill) begin
      for (int i = 0; i < len; i++) push(1, da + 32'(4 * i), fdata, i + 1);
      tot = len + 1;
    end else begin
      for (int i = 0; i < len; i++) begin
        logic [31:0] ra;
        ra = sa + 32'(4 * i);
        push(0, ra, 32'h0, 2 * i + 1);
        push(1, da + 32'(4 * i), mem[ra[9:2]], 2 * i + 2);
      end
      tot = 2 * len + 1;
    end
    push(2, 32'h0, 32'h0, tot);
    drive_start(src, dst, len, fill, fdata);
    for (int r = 1; r <= tot; r++) begin
      @(negedge clk);
      check("busy_high", {31'b0, Busy}, 32'd1);
      if (poke && r == 1) begin
        Src_addr = 32'h80;
        Dst_addr = 32'h300;
        Length   = LenW'(1);
        Start    = 1'b1;
      end
      if (poke && r == 2) Start = 1'b0;
    end
    @(negedge clk);
    check("busy_low_after_done", {31'b0, Busy}, 32'd0);
    check("all_events_seen", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = sentinel(i);
    for (int i = 0; i < 4; i++) mem[32 + i] = 32'(i + 1);

    // Reset state.
    #12;
    check("reset_busy_done", {30'b0, Busy, Done}, 32'd0);
    check("reset_rd_wr", {30'b0, MemRead, MemWrite}, 32'd0);
    check("reset_address", Address, 32'h0);
    check("reset_write_data", Write_data, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Four-word copy 0x80 -> 0x100.
    run_xfer(32'h80, 32'h100, 4, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) check("copy_word", mem[64 + i], 32'(i + 1));

    // Zero length: only a Done on cycle 1.
    run_xfer(32'h40, 32'h140, 0, 1'b0, 32'h0, 1'b0);
    check("zero_len_untouched", mem[80], sentinel(80));

    // Misaligned addresses, plus a Start while busy aimed at 0x300.
    run_xfer(32'h83, 32'h202, 1, 1'b0, 32'h0, 1'b1);
    check("misaligned_dst", mem[128], 32'd1);
    check("busy_start_ignored", mem[192], sentinel(192));

    // Reset during the second WRITE of a four-word copy 0x80 -> 0x180.
    push(0, 32'h80, 32'h0, 1);
    push(1, 32'h180, 32'd1, 2);
    push(0, 32'h84, 32'h0, 3);
    drive_start(32'h80, 32'h180, 4, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("reset_kills_memwrite", {31'b0, MemWrite}, 32'd0);
    check("reset_kills_busy", {31'b0, Busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_events_seen", 32'(exp_q.size()), 32'd0);
    check("reset_first_word", mem[96], 32'd1);
    check("reset_second_word", mem[97], sentinel(97));
    run_xfer(32'h84, 32'h1C0, 1, 1'b0, 32'h0, 1'b0);
    check("restart_word", mem[112], 32'd2);

    // Destination wrap-around past 0xFFFFFFFC.
    run_xfer(32'h88, 32'hFFFF_FFFC, 2, 1'b0, 32'h0, 1'b0);
    check("wrap_word0", mem[255], 32'd3);
    check("wrap_word1", mem[0], 32'd4);

`ifdef MEM_COPY_FILL_EN
    // Fill three words at 0x40; any MemRead pops a mismatching event.
    run_xfer(32'h0, 32'h40, 3, 1'b1, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 3; i++) check("fill_word", mem[16 + i], 32'hDEAD_BEEF);
    check("fill_bounded", mem[19], sentinel(19));
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
